// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Purpose:
//   Two-requester add/subtract engine that shares one 4-bit ripple adder.
//   A round-robin arbiter grants one requester at a time. The 8-bit operation
//   then runs as two nibble passes (LOW then HIGH) through the same adder, and
//   the result is held in DONE until the consumer accepts it.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   req0_valid   requester 0 has an operation pending
//   req0_ready   requester 0 accepted this cycle (one-cycle grant pulse)
//   req0_a/b     requester 0 operands, 8 bits each
//   req0_sub     requester 0 op: 0 = A+B, 1 = A-B
//   req1_*       same set of signals for requester 1
//   rsp_valid    result available (DONE state only)
//   rsp_ready    consumer accepts the result
//   rsp_id       index of the requester that owns the result
//   rsp_result   A+B or A-B modulo 256
//   rsp_carry    carry out of bit 7; for subtract, 1 = no borrow
// -----------------------------------------------------------------------------

// Plain 4-bit ripple-carry adder, used as the single shared arithmetic unit.
module four_bit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] carry_w;

    assign carry_w[0] = cin_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum_o[gi]       = a_i[gi] ^ b_i[gi] ^ carry_w[gi];
            assign carry_w[gi + 1] = (a_i[gi] & b_i[gi]) |
                                     (carry_w[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign cout_o = carry_w[4];
endmodule

module addsub_arbiter (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_sub,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_sub,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q,  state_d;
    logic       last_q,   last_d;     // requester served most recently
    logic [7:0] a_q,      a_d;
    logic [7:0] b_q,      b_d;
    logic       op_q,     op_d;       // 1 = subtract
    logic       id_q,     id_d;
    logic [7:0] result_q, result_d;
    logic       carry_q,  carry_d;
    logic       c_mid_q,  c_mid_d;    // carry from low nibble into high nibble

    logic       gnt0;
    logic       gnt1;

    // Shared adder operand selection. Only HIGH works on the upper nibble;
    // in every other state the adder sees the lower nibble, which is what
    // LOW needs and is harmless elsewhere because nothing is registered.
    logic       hi_sel;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    assign hi_sel  = (state_q == HIGH);
    assign add_a   = hi_sel ? a_q[7:4] : a_q[3:0];
    // Subtract is A + ~B + 1: invert B with the op bit and feed op as Cin
    // for the low nibble; the high nibble chains from c_mid.
    assign add_b   = (hi_sel ? b_q[7:4] : b_q[3:0]) ^ {4{op_q}};
    assign add_cin = hi_sel ? c_mid_q : op_q;

    four_bit_adder u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Arbitration: only in IDLE. On contention, last_q == 1 means requester 1
    // was served last, so requester 0 wins, and vice versa.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        result_d = result_q;
        carry_d  = carry_q;
        c_mid_d  = c_mid_q;

        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a   : req0_a;
                    b_d     = gnt1 ? req1_b   : req0_b;
                    op_d    = gnt1 ? req1_sub : req0_sub;
                    id_d    = gnt1;
                    state_d = LOW;
                end
            end
            LOW: begin
                result_d[3:0] = add_sum;
                c_mid_d       = add_cout;
                state_d       = HIGH;
            end
            HIGH: begin
                result_d[7:4] = add_sum;
                carry_d       = add_cout;
                state_d       = DONE;
            end
            DONE: begin
                // The handshake cycle never grants; the next grant can only
                // happen from the IDLE cycle that follows.
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 1'b0;
            id_q     <= 1'b0;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            c_mid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            c_mid_q  <= c_mid_d;
        end
    end

    // Outputs are forced low while rst is high so that even the very first
    // reset cycle (before any register has been cleared) presents zeros.
    assign req0_ready = gnt0 & ~rst;
    assign req1_ready = gnt1 & ~rst;
    assign rsp_valid  = (state_q == DONE) & ~rst;
    assign rsp_id     = id_q & ~rst;
    assign rsp_result = rst ? 8'h00 : result_q;
    assign rsp_carry  = carry_q & ~rst;

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands (unsigned / two's complement).
REQ-007 req0_sub  input  1  requester 0 op: 0 = A+B, 1 = A-B.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester index that owns the result.
REQ-012 rsp_result  output  8  A+B or A-B modulo 256.
REQ-013 rsp_carry  output  1  carry out of bit 7; for subtract, 1 = no borrow (A >= B unsigned).

Function
REQ-014 All arithmetic SHALL pass through one shared four_bit_adder instance; B-nibble inversion is XOR with the latched op bit.
REQ-015 The FSM states SHALL be IDLE, LOW, HIGH and DONE.
REQ-016 IDLE, no valid: stay in IDLE; both ready outputs = 0.
REQ-017 IDLE, exactly one valid: grant that requester.
REQ-018 IDLE, both valid: grant the requester selected by the round-robin pointer `last`, which favours the requester not most recently served.
REQ-019 Grant SHALL assert the granted reqN_ready for exactly that cycle; ready is combinational from state, valids and `last`.
REQ-020 The non-granted ready SHALL be 0.
REQ-021 On grant, operands, op and id SHALL be latched; next state = LOW.
REQ-022 reqN_ready SHALL be 0 in LOW, HIGH and DONE; requests wait without loss.
REQ-023 LOW: adder computes a[3:0] + (b[3:0]^{4{op}}) with Cin = op; register sum into result[3:0] and carry into c_mid; next state = HIGH.
REQ-024 HIGH: adder computes a[7:4] + (b[7:4]^{4{op}}) with Cin = c_mid; register sum into result[7:4] and carry into rsp_carry; next state = DONE.
REQ-025 DONE: rsp_valid = 1; rsp_id, rsp_result and rsp_carry SHALL be held stable until rsp_ready = 1.
REQ-026 On rsp_valid & rsp_ready: next state = IDLE; `last` <= rsp_id.
REQ-027 Latency: grant at cycle T gives rsp_valid first high at T+3; minimum issue interval is 4 cycles.
REQ-028 No grant SHALL occur in the DONE cycle that completes the response handshake; the earliest next grant is the following IDLE cycle.
REQ-029 rsp_valid SHALL be 0 outside DONE.
REQ-030 A requester dropping valid before it is granted SHALL NOT be captured.
REQ-031 Operand changes after grant SHALL NOT affect the in-flight result.
REQ-032 Overflow wraps modulo 256; no signed-overflow flag is provided.

Reset
REQ-033 While rst = 1 at a clock edge, the FSM SHALL go to IDLE and `last` SHALL be set to 1, so requester 0 wins the first contention.
REQ-034 While rst = 1, rsp_result, rsp_carry, rsp_id, c_mid and rsp_valid SHALL be 0, and both readys SHALL be 0 during the reset cycle.
REQ-035 Reset mid-operation (LOW, HIGH or DONE) SHALL discard the operation without producing a response.

Verification
REQ-036 Single add: req0 A=0x3C, B=0x19, sub=0 -> rsp_result=0x55, carry=0, id=0, rsp_valid 3 cycles after grant.
REQ-037 Subtract with borrow: req1 A=0x05, B=0x10, sub=1 -> rsp_result=0xF5, carry=0, id=1.
REQ-038 Cross-nibble carry: A=0xFF, B=0x01, add -> rsp_result=0x00, carry=1.
REQ-039 Subtract no borrow: A=0x80, B=0x80 -> rsp_result=0x00, carry=1.
REQ-040 Contention: both valid continuously after reset -> grants ordered 0,1,0,1; each requester's ready is a one-cycle pulse.
REQ-041 Backpressure and reset: hold rsp_ready=0 for 5 cycles in DONE -> outputs stable and no new grant.
REQ-042 Reset mid-op: assert rst during HIGH -> no rsp_valid afterwards, state IDLE, next contention grants requester 0.
